cmd_rr_sched: RTL and testbench
===============================

Name: cmd_rr_sched

Overview:
- Round-robin command scheduler.
- Shares one command slot among NREQ requesters and enforces a minimum spacing of TCCD cycles between issued commands.
- Tracks each issued command through a CL-deep valid/source delay pipeline, so the data path knows when, and for whom, to expect data.
- Sits between the per-bank request queues and the command/address output stage of the DDR5 controller.

Parameters:
- NREQ, 4: number of requesters; power of two, 2..8.
- CMD_W, 5: command word width.
- TCCD, 4: minimum cycles between successive grants; 1..15; 1 means back-to-back.
- CL, 3: cycles from cmd_valid to rdata_en; 1..16.
- SRC_W, 2: width of the requester index, equal to log2(NREQ).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; must be held, with its command stable, until ready.
- req_cmd  in  NREQ*CMD_W  packed commands; requester i occupies bits [i*CMD_W +: CMD_W].
- req_ready  out  NREQ  one-hot grant, combinational, high in the transfer cycle.
- cmd_valid  out  1  registered one-cycle pulse: command issued.
- cmd_out  out  CMD_W  registered issued command.
- cmd_src  out  SRC_W  registered index of the issuing requester.
- rdata_en  out  1  cmd_valid delayed by exactly CL cycles.
- rdata_src  out  SRC_W  cmd_src delayed by exactly CL cycles.
- busy  out  1  high while the gap counter is nonzero or any pipeline stage is valid.

Behaviour:

Reset (async, immediate):
- All outputs go to 0: cmd_valid, cmd_out, cmd_src, rdata_en, rdata_src, busy.
- Gap counter = 0, priority pointer = 0, all pipeline stages cleared.
- A command in flight when reset asserts is discarded; no rdata_en is produced for it after reset releases.

Handshake:
- A transfer occurs on a cycle where req_valid[i] and req_ready[i] are both high.
- req_ready is all-zero when no grant is allowed.
- req_ready never depends on req_cmd.

State machine:
- IDLE (gap counter == 0):
  - Grant is allowed.
  - If any req_valid is high, grant winner g, load the gap counter with TCCD-1, and go to GAP. If TCCD == 1, stay in IDLE.
  - If no req_valid is high, stay in IDLE.
- GAP (gap counter > 0):
  - req_ready = 0.
  - Decrement the counter each cycle; return to IDLE when it reaches 0.
- Resulting grant spacing is exactly TCCD cycles under continuous requests.

Arbitration:
- Round-robin search starting at pointer p, in the order p, p+1, ..., wrapping mod NREQ.
- The first requester with req_valid high wins.
- After granting g, p <= (g+1) mod NREQ. The pointer is unchanged when there is no grant.

Latency:
- Grant in cycle N gives cmd_valid/cmd_out/cmd_src in cycle N+1, and rdata_en/rdata_src in cycle N+1+CL.
- cmd_out and cmd_src hold their last values when cmd_valid = 0.
- rdata_src is 0 when rdata_en = 0.

Pipeline:
- CL stages of {valid, src}, shifted every cycle with no stall.
- Multiple commands may be in flight at once (CL > TCCD is legal).

Simultaneous events:
- A grant may occur in the same cycle that an older command exits the pipeline; both are honoured.
- A requester deasserting req_valid without being granted is legal; it is simply not granted.

Widths:
- The gap counter is 4 bits.
- The pointer is SRC_W bits and wraps naturally.

Decomposition:
- Package cmd_sched_pkg holds:
  - the state enum: IDLE, GAP;
  - shared default constants for TCCD and CL;
  - the SRC_W derivation function.
- Sub-module lat_pipe #(DEPTH=CL, WIDTH=1+SRC_W): a resettable DFF chain that is the {valid, src} delay line.
- The arbiter, counter and FSM live in the top module.

Test Plan:
1. Reset mid-flight: grant req1, assert rst 2 cycles later, then release -> all outputs are 0; no rdata_en ever appears for req1; the first post-reset grant goes to req0 when all requesters are valid.
2. Single request: req_valid[2] = 1 with cmd 5'h0A at cycle 10 -> req_ready = 4'b0100 at cycle 10; cmd_valid with cmd_out = 0x0A and cmd_src = 2 at cycle 11; rdata_en with rdata_src = 2 at cycle 14.
3. All four requesting continuously, TCCD = 4 -> grants at cycles 0, 4, 8, 12 in order 0, 1, 2, 3, then 0 again at 16; req_ready is zero in all other cycles.
4. TCCD = 1, CL = 3, req0 and req3 both continuous -> grants alternate 0, 3, 0, 3 on consecutive cycles; rdata_en stays high continuously, 3 cycles behind cmd_valid, with alternating rdata_src.
5. Pointer wrap: last grant to req3, then only req1 and req2 valid -> req1 granted next, then req2.
6. busy check: one grant with TCCD = 4, CL = 3 -> busy is high from the cycle after the grant until rdata_en has been emitted, then drops to 0.

Source files
------------

// File: rtl/cmd_sched_pkg.sv
// Shared types, defaults and helpers for the round-robin command scheduler.
package cmd_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_e;

  localparam int unsigned TCCD_DEF = 4;
  localparam int unsigned CL_DEF   = 3;
  localparam int unsigned GAP_W    = 4;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned src_w_f(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lat_pipe.sv
// Resettable fixed-latency delay line; every stage is visible for occupancy checks.
module lat_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            i_din,
  output logic [WIDTH-1:0]            o_dout,
  output logic [DEPTH-1:0][WIDTH-1:0] o_stages
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  // Shift one stage per cycle, no stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dout   = r_stage[DEPTH-1];
  assign o_stages = r_stage;

endmodule

// File: rtl/cmd_rr_sched.sv
// Round-robin command scheduler with tCCD spacing and a CL-deep data-return tracker.
module cmd_rr_sched
  import cmd_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CMD_W = 5,
  parameter int unsigned TCCD  = TCCD_DEF,
  parameter int unsigned CL    = CL_DEF,
  parameter int unsigned SRC_W = src_w_f(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*CMD_W-1:0]   req_cmd,
  output logic [NREQ-1:0]         req_ready,
  output logic                    cmd_valid,
  output logic [CMD_W-1:0]        cmd_out,
  output logic [SRC_W-1:0]        cmd_src,
  output logic                    rdata_en,
  output logic [SRC_W-1:0]        rdata_src,
  output logic                    busy
);

  localparam int unsigned     PIPE_W   = 1 + SRC_W;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TCCD - 1);

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [GAP_W-1:0]            r_gap;
  logic [GAP_W-1:0]            w_gap_nxt;
  logic [SRC_W-1:0]            r_ptr;
  logic [SRC_W-1:0]            w_idx;
  logic                        w_grant;
  logic                        w_fire;
  logic [SRC_W-1:0]            w_win;
  logic [CMD_W-1:0]            w_win_cmd;
  logic                        r_cmd_valid;
  logic [CMD_W-1:0]            r_cmd_out;
  logic [SRC_W-1:0]            r_cmd_src;
  logic [PIPE_W-1:0]           w_pipe_din;
  logic [PIPE_W-1:0]           w_pipe_dout;
  logic [CL-1:0][PIPE_W-1:0]   w_pipe_stages;
  logic                        w_pipe_any;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    w_grant = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_ptr + SRC_W'(k);
      if (!w_grant && req_valid[w_idx]) begin
        w_grant = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_fire    = (r_state == IDLE) && w_grant;
  assign w_win_cmd = req_cmd[w_win*CMD_W +: CMD_W];

  // Next-state and grant decode; no grant while in reset or during the gap.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (w_grant && !rst) begin
          req_ready[w_win] = 1'b1;
          w_gap_nxt        = GAP_LOAD;
          w_state_nxt      = (TCCD > 1) ? GAP : IDLE;
        end
      end
      GAP: begin
        w_gap_nxt = r_gap - GAP_W'(1);
        if (r_gap == GAP_W'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM, gap counter and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gap   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      if (w_fire) begin
        r_ptr <= w_win + SRC_W'(1);
      end
    end
  end

  // Issued-command register; command and source hold between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_out   <= '0;
      r_cmd_src   <= '0;
    end else begin
      r_cmd_valid <= w_fire;
      if (w_fire) begin
        r_cmd_out <= w_win_cmd;
        r_cmd_src <= w_win;
      end
    end
  end

  // Source is zeroed for empty slots so rdata_src reads 0 when idle.
  assign w_pipe_din = {r_cmd_valid, r_cmd_valid ? r_cmd_src : SRC_W'(0)};

  lat_pipe #(
    .DEPTH (CL),
    .WIDTH (PIPE_W)
  ) u_lat_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_din    (w_pipe_din),
    .o_dout   (w_pipe_dout),
    .o_stages (w_pipe_stages)
  );

  // Any command still travelling toward its data-return slot.
  always_comb begin
    w_pipe_any = 1'b0;
    for (int i = 0; i < CL; i++) begin
      w_pipe_any = w_pipe_any | w_pipe_stages[i][PIPE_W-1];
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_out   = r_cmd_out;
  assign cmd_src   = r_cmd_src;
  assign rdata_en  = w_pipe_dout[PIPE_W-1];
  assign rdata_src = w_pipe_dout[SRC_W-1:0];
  assign busy      = (r_gap != '0) || w_pipe_any;

endmodule

// File: tb/tb_cmd_rr_sched.sv
// Bench for cmd_rr_sched: two instances (TCCD=4 and TCCD=1, both CL=3) checked
// every cycle against a cycle-count model, plus directed literal expectations.
module tb_cmd_rr_sched;

  localparam int CLAT  = 3;
  localparam int TC[2] = '{4, 1};

  logic        clk = 1'b0;
  logic        rst  [2];
  logic [3:0]  vin  [2];
  logic [19:0] cin  [2];
  logic [3:0]  rdy  [2];
  logic        cv   [2];
  logic [4:0]  co   [2];
  logic [1:0]  cs   [2];
  logic        re   [2];
  logic [1:0]  rs   [2];
  logic        bz   [2];

  int n_chk  = 0;
  int n_pass = 0;

  // model state: cycle count since reset, first cycle a grant is allowed,
  // pointer, held command, and a ring of issue flags indexed by cycle
  int m_t [2];
  int m_nok [2];
  int m_ptr [2];
  int m_out [2];
  int m_src [2];
  bit iss_v [2][64];
  int iss_s [2][64];

  always #5 clk = ~clk;

  cmd_rr_sched #(.NREQ(4), .CMD_W(5), .TCCD(4), .CL(CLAT), .SRC_W(2)) u_a (
    .clk(clk), .rst(rst[0]), .req_valid(vin[0]), .req_cmd(cin[0]), .req_ready(rdy[0]),
    .cmd_valid(cv[0]), .cmd_out(co[0]), .cmd_src(cs[0]), .rdata_en(re[0]),
    .rdata_src(rs[0]), .busy(bz[0]));

  cmd_rr_sched #(.NREQ(4), .CMD_W(5), .TCCD(1), .CL(CLAT), .SRC_W(2)) u_b (
    .clk(clk), .rst(rst[1]), .req_valid(vin[1]), .req_cmd(cin[1]), .req_ready(rdy[1]),
    .cmd_valid(cv[1]), .cmd_out(co[1]), .cmd_src(cs[1]), .rdata_en(re[1]),
    .rdata_src(rs[1]), .busy(bz[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic m_reset(input int d);
    m_t[d] = 0; m_nok[d] = 0; m_ptr[d] = 0; m_out[d] = 0; m_src[d] = 0;
    for (int i = 0; i < 64; i++) begin iss_v[d][i] = 1'b0; iss_s[d][i] = 0; end
  endtask

  function automatic int rr_win(input int d);
    if (rst[d] || m_t[d] < m_nok[d]) return -1;
    for (int k = 0; k < 4; k++)
      if (vin[d][(m_ptr[d] + k) % 4]) return (m_ptr[d] + k) % 4;
    return -1;
  endfunction

  // model advance on each rising edge
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) m_reset(d);
      else begin
        int g;
        g = rr_win(d);
        m_t[d]++;
        iss_v[d][m_t[d] % 64] = (g >= 0);
        if (g >= 0) begin
          iss_s[d][m_t[d] % 64] = g;
          m_out[d] = int'(cin[d][g*5 +: 5]);
          m_src[d] = g;
          m_nok[d] = m_t[d] - 1 + TC[d];
          m_ptr[d] = (g + 1) % 4;
        end
      end
    end
  end

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int g; int t; logic e_re; int e_rs; logic e_bz;
      t = m_t[d];
      g = rr_win(d);
      e_re = (t >= CLAT) ? iss_v[d][(t - CLAT) % 64] : 1'b0;
      e_rs = e_re ? iss_s[d][(t - CLAT) % 64] : 0;
      e_bz = (t < m_nok[d]);
      for (int k = 1; k <= CLAT; k++)
        if (t - k >= 0 && iss_v[d][(t - k) % 64]) e_bz = 1'b1;
      chk($sformatf("m%0d.req_ready", d), 32'(rdy[d]), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk($sformatf("m%0d.cmd_valid", d), 32'(cv[d]), 32'(iss_v[d][t % 64]));
      chk($sformatf("m%0d.cmd_out", d), 32'(co[d]), 32'(m_out[d]));
      chk($sformatf("m%0d.cmd_src", d), 32'(cs[d]), 32'(m_src[d]));
      chk($sformatf("m%0d.rdata_en", d), 32'(re[d]), 32'(e_re));
      chk($sformatf("m%0d.rdata_src", d), 32'(rs[d]), 32'(e_rs));
      chk($sformatf("m%0d.busy", d), 32'(bz[d]), 32'(e_bz));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gp [2];
    int rcnt [2];
    rst[0] = 1'b1; rst[1] = 1'b1;
    vin[0] = '0; vin[1] = '0; cin[0] = '0; cin[1] = '0;
    m_reset(0); m_reset(1);
    tick(); tick();
    #1;
    chk("rst.cmd_valid", 32'(cv[0]), 0);
    chk("rst.busy", 32'(bz[0]), 0);
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // TCCD=1: req0 and req3 alternate every cycle; rdata follows 3 cycles behind
    vin[1] = 4'b1001; cin[1] = {5'h1C, 5'h00, 5'h00, 5'h03};
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("t4.ready", 32'(rdy[1]), (i % 2 == 0) ? 32'h1 : 32'h8);
      if (i >= 1) chk("t4.cmd_src", 32'(cs[1]), (i % 2 == 1) ? 0 : 3);
      if (i >= 4) begin
        chk("t4.rdata_en", 32'(re[1]), 1);
        chk("t4.rdata_src", 32'(rs[1]), (i % 2 == 0) ? 0 : 3);
      end
      tick();
    end
    vin[1] = '0;
    tick(); tick(); tick(); tick(); tick();

    // single request from req2 with busy tracking
    vin[0] = 4'b0100; cin[0] = 20'h0; cin[0][14:10] = 5'h0A;
    #1; chk("t2.ready", 32'(rdy[0]), 32'h4);
    tick(); vin[0] = '0; #1;
    chk("t2.cmd_valid", 32'(cv[0]), 1);
    chk("t2.cmd_out", 32'(co[0]), 32'h0A);
    chk("t2.cmd_src", 32'(cs[0]), 2);
    chk("t6.busy1", 32'(bz[0]), 1);
    tick(); #1;
    chk("t2.cmd_hold", 32'(co[0]), 32'h0A);
    chk("t2.cmd_valid0", 32'(cv[0]), 0);
    chk("t6.busy2", 32'(bz[0]), 1);
    tick(); #1;
    chk("t6.busy3", 32'(bz[0]), 1);
    chk("t2.rdata_early", 32'(re[0]), 0);
    tick(); #1;
    chk("t2.rdata_en", 32'(re[0]), 1);
    chk("t2.rdata_src", 32'(rs[0]), 2);
    chk("t6.busy4", 32'(bz[0]), 1);
    tick(); #1;
    chk("t2.rdata_done", 32'(re[0]), 0);
    chk("t6.busy_low", 32'(bz[0]), 0);
    tick();

    // reset while a req1 command is in flight
    vin[0] = 4'b0010; cin[0][9:5] = 5'h11;
    #1; chk("t1.ready", 32'(rdy[0]), 32'h2);
    tick(); vin[0] = '0;
    #1; chk("t1.cmd_src", 32'(cs[0]), 1);
    tick();
    rst[0] = 1'b1; m_reset(0);
    #1;
    chk("t1.cmd_valid", 32'(cv[0]), 0);
    chk("t1.cmd_out", 32'(co[0]), 0);
    chk("t1.cmd_src0", 32'(cs[0]), 0);
    chk("t1.rdata_en", 32'(re[0]), 0);
    chk("t1.busy", 32'(bz[0]), 0);
    tick(); tick();
    rst[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; chk("t1.no_rdata", 32'(re[0]), 0);
      tick();
    end

    // all four continuous: grants every 4 cycles in order 0,1,2,3,0
    vin[0] = 4'b1111; cin[0] = {5'h04, 5'h03, 5'h02, 5'h01};
    for (int i = 0; i <= 16; i++) begin
      #1;
      chk("t3.ready", 32'(rdy[0]), (i % 4 == 0) ? (32'd1 << ((i / 4) % 4)) : 32'd0);
      tick();
    end
    vin[0] = '0;
    tick(); tick(); tick();
    // pointer wrap: grant req3, then only req1/req2
    vin[0] = 4'b1000;
    #1; chk("t5.ready3", 32'(rdy[0]), 32'h8);
    tick(); vin[0] = 4'b0110;
    tick(); tick(); tick();
    #1; chk("t5.ready1", 32'(rdy[0]), 32'h2);
    tick(); vin[0] = 4'b0100;
    tick(); tick(); tick();
    #1; chk("t5.ready2", 32'(rdy[0]), 32'h4);
    tick(); vin[0] = '0;
    tick(); tick(); tick(); tick(); tick();

    // randomized traffic with hold-until-ready, drops and occasional resets
    gp[0] = -1; gp[1] = -1; rcnt[0] = 0; rcnt[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          if (vin[d][i]) begin
            if (gp[d] == i || $urandom_range(0, 99) < 3) vin[d][i] = 1'b0;
          end else if ($urandom_range(0, 99) < 35) begin
            cin[d][i*5 +: 5] = 5'($urandom);
            vin[d][i] = 1'b1;
          end
        end
        if (rcnt[d] > 0) begin
          rcnt[d]--;
          if (rcnt[d] == 0) rst[d] = 1'b0;
        end else if ($urandom_range(0, 399) == 0) begin
          rst[d] = 1'b1; m_reset(d);
          rcnt[d] = $urandom_range(1, 2);
        end
      end
      #1;
      gp[0] = rr_win(0); gp[1] = rr_win(1);
      tick();
    end

    rst[0] = 1'b0; rst[1] = 1'b0;
    vin[0] = '0; vin[1] = '0;
    tick(); tick(); tick(); tick(); tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
